seq_fixed_divider: RTL and testbench

Parametrised multi-cycle divider for the CPU datapath's mean/covariance programs. Divides a signed or unsigned fixed-point dividend by an unsigned integer count. The quotient keeps the dividend's Q format; at defaults this is 8.8 / 8-bit N.
Signed results round toward minus infinity. This is bit-exact with the team's golden model, which takes the top 16 bits of (dividend<<48)/N with sign correction.
Sits beside the ALU with a Start/Done handshake and replaces the software divide loop.

---
 rtl/seq_fixed_divider_pkg.sv | 15 +
 rtl/seq_fixed_divider_if.sv | 28 ++
 rtl/seq_fixed_divider_div_step.sv | 22 ++
 rtl/seq_fixed_divider.sv | 131 +++++++++++++
 tb/tb_seq_fixed_divider.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_fixed_divider_pkg.sv
// Shared definitions for the sequential fixed-point divider: FSM encoding and default widths
// reused by the CPU top level.
package seq_fixed_divider_pkg;

  localparam int unsigned DefDividendW = 16;
  localparam int unsigned DefDivisorW  = 8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StDiv  = 2'd1,
    StFix  = 2'd2,
    StDone = 2'd3
  } state_e;

endpackage

// File: rtl/seq_fixed_divider_if.sv
// Start/Done handshake bundle between the ALU-side requester (master) and the divider (slave).
interface seq_fixed_divider_if
  import seq_fixed_divider_pkg::*;
#(
  parameter int unsigned DIVIDEND_W = DefDividendW,
  parameter int unsigned DIVISOR_W  = DefDivisorW
);

  logic                  start;
  logic                  is_signed;
  logic [DIVIDEND_W-1:0] dividend;
  logic [DIVISOR_W-1:0]  divisor;
  logic                  busy;
  logic                  done;
  logic [DIVIDEND_W-1:0] quotient;
  logic                  div_zero;

  modport master (
    output start, is_signed, dividend, divisor,
    input  busy, done, quotient, div_zero
  );

  modport slave (
    input  start, is_signed, dividend, divisor,
    output busy, done, quotient, div_zero
  );

endinterface

// File: rtl/seq_fixed_divider_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the remainder and keep the
// trial difference when it does not underflow.
module seq_fixed_divider_div_step #(
  parameter int unsigned DIVISOR_W = 8
) (
  input  logic [DIVISOR_W-1:0] rem_in,
  input  logic                 bit_in,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic [DIVISOR_W-1:0] rem_out,
  output logic                 q_bit
);

  logic [DIVISOR_W:0]   partial;
  logic [DIVISOR_W-1:0] diff;

  assign partial = {rem_in, bit_in};
  assign q_bit   = (partial >= {1'b0, divisor});
  // When the subtract succeeds the difference is below the divisor, so its top bit is always zero.
  assign diff    = DIVISOR_W'(partial - {1'b0, divisor});
  assign rem_out = q_bit ? diff : partial[DIVISOR_W-1:0];

endmodule

// File: rtl/seq_fixed_divider.sv
// Multi-cycle fixed-point divider: |dividend| / unsigned divisor, one quotient bit per cycle,
// then floor correction for negative signed dividends.
module seq_fixed_divider
  import seq_fixed_divider_pkg::*;
#(
  parameter int unsigned DIVIDEND_W = DefDividendW,
  parameter int unsigned DIVISOR_W  = DefDivisorW
) (
  input  logic               clk,
  input  logic               rst_n,
  seq_fixed_divider_if.slave bus
);

  localparam int unsigned           CntW     = $clog2(DIVIDEND_W + 1);
  localparam logic [CntW-1:0]       LastIter = CntW'(DIVIDEND_W - 1);
  localparam logic [DIVIDEND_W-1:0] MinNeg   = {1'b1, {(DIVIDEND_W - 1){1'b0}}};
  localparam logic [DIVIDEND_W-1:0] MaxPos   = ~MinNeg;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [DIVIDEND_W-1:0] quo_q, quo_d;
  logic [DIVISOR_W-1:0]  rem_q, rem_d;
  logic [DIVISOR_W-1:0]  divisor_q, divisor_d;
  logic                  neg_q, neg_d;
  logic [DIVIDEND_W-1:0] quotient_q, quotient_d;
  logic                  div_zero_q, div_zero_d;

  logic                  start_neg;
  logic [DIVIDEND_W-1:0] start_mag;
  logic [DIVISOR_W-1:0]  step_rem;
  logic                  step_q;
  logic                  rem_nz;
  logic [DIVIDEND_W-1:0] fix_result;

  // Only signed mode with a set MSB needs correction, so the mode bit folds into one flag.
  assign start_neg = bus.is_signed & bus.dividend[DIVIDEND_W-1];
  assign start_mag = start_neg ? -bus.dividend : bus.dividend;

  seq_fixed_divider_div_step #(
    .DIVISOR_W(DIVISOR_W)
  ) u_div_step (
    .rem_in (rem_q),
    .bit_in (quo_q[DIVIDEND_W-1]),
    .divisor(divisor_q),
    .rem_out(step_rem),
    .q_bit  (step_q)
  );

  assign rem_nz     = |rem_q;
  assign fix_result = neg_q ? -(quo_q + DIVIDEND_W'(rem_nz)) : quo_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    quo_d      = quo_q;
    rem_d      = rem_q;
    divisor_d  = divisor_q;
    neg_d      = neg_q;
    quotient_d = quotient_q;
    div_zero_d = div_zero_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          neg_d     = start_neg;
          divisor_d = bus.divisor;
          quo_d     = start_mag;
          rem_d     = '0;
          cnt_d     = '0;
          if (bus.divisor == '0) begin
            state_d    = StDone;
            div_zero_d = 1'b1;
            if (!bus.is_signed) begin
              quotient_d = '1;
            end else begin
              quotient_d = start_neg ? MinNeg : MaxPos;
            end
          end else begin
            state_d = StDiv;
          end
        end
      end
      StDiv: begin
        quo_d = {quo_q[DIVIDEND_W-2:0], step_q};
        rem_d = step_rem;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastIter) begin
          state_d = StFix;
        end
      end
      StFix: begin
        quotient_d = fix_result;
        div_zero_d = 1'b0;
        state_d    = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      quo_q      <= '0;
      rem_q      <= '0;
      divisor_q  <= '0;
      neg_q      <= 1'b0;
      quotient_q <= '0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      quo_q      <= quo_d;
      rem_q      <= rem_d;
      divisor_q  <= divisor_d;
      neg_q      <= neg_d;
      quotient_q <= quotient_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign bus.busy     = (state_q != StIdle);
  assign bus.done     = (state_q == StDone);
  assign bus.quotient = quotient_q;
  assign bus.div_zero = div_zero_q;

endmodule

// File: tb/tb_seq_fixed_divider.sv
// Self-checking bench: directed vector table, handshake corner sequences and a randomized sweep
// at 16/8 and 24/12 widths against a plain-arithmetic floor/truncate reference.
module tb_seq_fixed_divider;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seq_fixed_divider_if #(.DIVIDEND_W(16), .DIVISOR_W(8))  bus16 ();
  seq_fixed_divider_if #(.DIVIDEND_W(24), .DIVISOR_W(12)) bus24 ();

  seq_fixed_divider #(.DIVIDEND_W(16), .DIVISOR_W(8)) u_dut16 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus16)
  );

  seq_fixed_divider #(.DIVIDEND_W(24), .DIVISOR_W(12)) u_dut24 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus24)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        sgn;
    logic [15:0] dvd;
    logic [7:0]  dvs;
    logic [15:0] exp_q;
    logic        exp_z;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: floor division for signed, truncation for unsigned, saturation on zero divisor.
  function automatic longint ref_q(input bit s, input longint a, input int w, input longint n,
                                   output bit z);
    longint mask;
    longint val;
    longint q;
    bit     neg;
    mask = (longint'(1) << w) - 1;
    neg  = s && (((a >> (w - 1)) & 1) == 1);
    z    = (n == 0);
    if (z) begin
      if (!s) return mask;
      return neg ? (longint'(1) << (w - 1)) : (longint'(1) << (w - 1)) - 1;
    end
    val = neg ? a - (longint'(1) << w) : a;
    q   = val / n;
    if ((val % n != 0) && (val < 0)) q = q - 1;
    return q & mask;
  endfunction

  task automatic op16(input logic s, input logic [15:0] a, input logic [7:0] b,
                      input int inject_at, output logic [15:0] q, output logic z,
                      output int lat, output bit busy_ok, output bit hold_ok, output bit pulse_ok);
    logic [15:0] prev;
    prev = bus16.quotient;
    @(negedge clk);
    bus16.start     = 1'b1;
    bus16.is_signed = s;
    bus16.dividend  = a;
    bus16.divisor   = b;
    @(negedge clk);
    bus16.start = 1'b0;
    lat         = 1;
    busy_ok     = 1'b1;
    hold_ok     = 1'b1;
    while (bus16.done !== 1'b1 && lat < 64) begin
      if (bus16.busy !== 1'b1) busy_ok = 1'b0;
      if (bus16.quotient !== prev) hold_ok = 1'b0;
      if (lat == inject_at) begin
        bus16.start     = 1'b1;
        bus16.is_signed = 1'b0;
        bus16.dividend  = 16'h0600;
        bus16.divisor   = 8'd2;
      end else begin
        bus16.start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    bus16.start = 1'b0;
    if (bus16.busy !== 1'b1) busy_ok = 1'b0;
    q = bus16.quotient;
    z = bus16.div_zero;
    @(negedge clk);
    pulse_ok = (bus16.done === 1'b0) && (bus16.busy === 1'b0);
  endtask

  task automatic run16(input string name, input logic s, input logic [15:0] a,
                       input logic [7:0] b, input logic [15:0] eq, input logic ez,
                       input int inject_at);
    logic [15:0] q;
    logic        z;
    int          lat;
    bit          bo, ho, po;
    op16(s, a, b, inject_at, q, z, lat, bo, ho, po);
    check({name, " quotient"}, 64'(q), 64'(eq));
    check({name, " div_zero"}, 64'(z), 64'(ez));
    check({name, " latency"}, 64'(lat), ez ? 64'd1 : 64'd18);
    check({name, " busy"}, 64'(bo), 64'd1);
    check({name, " hold"}, 64'(ho), 64'd1);
    check({name, " done_pulse"}, 64'(po), 64'd1);
  endtask

  task automatic run24(input logic s, input logic [23:0] a, input logic [11:0] b,
                       input logic [23:0] eq, input logic ez);
    int lat;
    @(negedge clk);
    bus24.start     = 1'b1;
    bus24.is_signed = s;
    bus24.dividend  = a;
    bus24.divisor   = b;
    @(negedge clk);
    bus24.start = 1'b0;
    lat         = 1;
    while (bus24.done !== 1'b1 && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    check("rnd24 quotient", 64'(bus24.quotient), 64'(eq));
    check("rnd24 div_zero", 64'(bus24.div_zero), 64'(ez));
    check("rnd24 latency", 64'(lat), ez ? 64'd1 : 64'd26);
  endtask

  initial begin
    vec_t vecs[13];
    bit   seen_done;
    logic [3:0] pattern;

    vecs[0]  = '{1'b1, 16'h1100, 8'd3,   16'h05AA, 1'b0};
    vecs[1]  = '{1'b1, 16'hFF00, 8'd3,   16'hFFAA, 1'b0};
    vecs[2]  = '{1'b0, 16'hFF00, 8'd3,   16'h5500, 1'b0};
    vecs[3]  = '{1'b1, 16'h8000, 8'd1,   16'h8000, 1'b0};
    vecs[4]  = '{1'b1, 16'h0600, 8'd3,   16'h0200, 1'b0};
    vecs[5]  = '{1'b1, 16'h0100, 8'd0,   16'h7FFF, 1'b1};
    vecs[6]  = '{1'b1, 16'hFF00, 8'd0,   16'h8000, 1'b1};
    vecs[7]  = '{1'b0, 16'h1234, 8'd0,   16'hFFFF, 1'b1};
    vecs[8]  = '{1'b1, 16'h0000, 8'd7,   16'h0000, 1'b0};
    vecs[9]  = '{1'b0, 16'hFFFF, 8'd255, 16'h0101, 1'b0};
    vecs[10] = '{1'b1, 16'hFFFF, 8'd255, 16'hFFFF, 1'b0};
    vecs[11] = '{1'b1, 16'h7FFF, 8'd1,   16'h7FFF, 1'b0};
    vecs[12] = '{1'b1, 16'h8000, 8'd255, 16'hFF7F, 1'b0};

    bus16.start = 1'b0; bus16.is_signed = 1'b0; bus16.dividend = '0; bus16.divisor = '0;
    bus24.start = 1'b0; bus24.is_signed = 1'b0; bus24.dividend = '0; bus24.divisor = '0;

    repeat (3) @(negedge clk);
    check("reset outputs16", {bus16.busy, bus16.done, bus16.div_zero, bus16.quotient}, 64'd0);
    check("reset outputs24", {bus24.busy, bus24.done, bus24.div_zero, bus24.quotient}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 13; i++) begin
      run16($sformatf("vec%0d", i), vecs[i].sgn, vecs[i].dvd, vecs[i].dvs, vecs[i].exp_q,
            vecs[i].exp_z, -1);
    end

    // Start held high: sampled in DONE is ignored, re-sampled in the following IDLE.
    @(negedge clk);
    bus16.start = 1'b1; bus16.is_signed = 1'b0; bus16.dividend = 16'h0042; bus16.divisor = 8'd0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      pattern[3-i] = bus16.done;
    end
    bus16.start = 1'b0;
    check("held start done pattern", 64'(pattern), 64'hA);
    check("held start quotient", 64'(bus16.quotient), 64'hFFFF);
    repeat (2) @(negedge clk);

    // Start pulsed mid-divide must be ignored; no second Done afterwards.
    run16("ignored_start", 1'b1, 16'h1100, 8'd3, 16'h05AA, 1'b0, 5);
    seen_done = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (bus16.done) seen_done = 1'b1;
    end
    check("ignored_start extra done", 64'(seen_done), 64'd0);

    // Reset during a divide abandons it.
    @(negedge clk);
    bus16.start = 1'b1; bus16.is_signed = 1'b1; bus16.dividend = 16'h1100; bus16.divisor = 8'd3;
    @(negedge clk);
    bus16.start = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset outputs", {bus16.busy, bus16.done, bus16.div_zero, bus16.quotient}, 64'd0);
    seen_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (bus16.done) seen_done = 1'b1;
    end
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (bus16.done) seen_done = 1'b1;
    end
    check("midreset stale done", 64'(seen_done), 64'd0);
    run16("after_reset", 1'b1, 16'h3900, 8'd3, 16'h1300, 1'b0, -1);

    for (int i = 0; i < 1500; i++) begin
      logic [15:0] a;
      logic [7:0]  b;
      logic        s;
      bit          z;
      longint      e;
      s = 1'($urandom_range(0, 1));
      a = (i % 16 == 0) ? 16'h8000 : 16'($urandom_range(0, 65535));
      b = 8'($urandom_range(0, 255));
      e = ref_q(s, longint'(a), 16, longint'(b), z);
      run16("rnd16", s, a, b, 16'(e), z, -1);
    end

    for (int i = 0; i < 1000; i++) begin
      logic [23:0] a;
      logic [11:0] b;
      logic        s;
      bit          z;
      longint      e;
      s = 1'($urandom_range(0, 1));
      a = (i % 16 == 0) ? 24'h800000 : 24'($urandom_range(0, 24'hFFFFFF));
      b = (i % 64 == 1) ? 12'd0 : 12'($urandom_range(0, 4095));
      e = ref_q(s, longint'(a), 24, longint'(b), z);
      run24(s, a, b, 24'(e), z);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
